// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Extracts HEADER | LEN | PAYLOAD[LEN] | CHK frames from a stream of received
// UART bytes. The payload is buffered and only released on the out_* stream
// once the checksum (LEN plus all payload bytes, mod 256) has verified.
// Malformed frames are discarded and reported on err_pulse/err_code.
// Optional feature: define PARSER_TIMEOUT_EN to abort frames that stall for
// TIMEOUT_CYC clock cycles between bytes (err_code 11).
module uart_frame_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 4500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] drop_cnt
);

    localparam int         PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t     state_q;
    logic [7:0] len_q;
    logic [7:0] sum_q;
    logic [7:0] wr_ptr_q;
    logic [7:0] rd_ptr_q;
    logic [7:0] buf_q [MAX_LEN];
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       out_last_q;
    logic       err_pulse_q;
    logic [1:0] err_code_q;
    logic [7:0] drop_cnt_q;

    logic [7:0] sum_d;
    logic [7:0] rd_ptr_d;
    logic [7:0] drop_cnt_d;
    logic       buf_we;
    logic       tmo_fire;

    assign sum_d      = sum_q + rx_data;
    assign rd_ptr_d   = rd_ptr_q + 8'd1;
    assign drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    assign buf_we     = (state_q == S_PAYLOAD) && rx_valid;

`ifdef PARSER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_q;
    logic          in_frame;

    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // A byte arriving on the expiry cycle wins, hence the !rx_valid term.
    assign tmo_fire = in_frame && !rx_valid && (tmo_q == TMO_LAST);

    // Inter-byte gap counter, only running while a frame is in progress.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || rx_valid) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_LAST) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Payload storage; contents need no reset because the pointers gate all use.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_ptr_q[PW-1:0]] <= rx_data;
        end
    end

    // Frame FSM with registered stream and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            drop_cnt_q  <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (tmo_fire) begin
                err_pulse_q <= 1'b1;
                err_code_q  <= 2'b11;
                wr_ptr_q    <= '0;
                state_q     <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_valid && rx_data == HEADER) begin
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_valid) begin
                            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                err_pulse_q <= 1'b1;
                                err_code_q  <= 2'b01;
                                state_q     <= S_IDLE;
                            end else begin
                                len_q    <= rx_data;
                                sum_q    <= rx_data;
                                wr_ptr_q <= '0;
                                state_q  <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_valid) begin
                            sum_q    <= sum_d;
                            wr_ptr_q <= wr_ptr_q + 8'd1;
                            if (wr_ptr_q == len_q - 8'd1) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (rx_valid) begin
                            if (rx_data == sum_q) begin
                                rd_ptr_q <= '0;
                                state_q  <= S_DRAIN;
                            end else begin
                                err_pulse_q <= 1'b1;
                                err_code_q  <= 2'b10;
                                wr_ptr_q    <= '0;
                                state_q     <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (rx_valid) begin
                            drop_cnt_q <= drop_cnt_d;
                        end
                        if (!out_valid_q) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= buf_q[0];
                            out_last_q  <= (len_q == 8'd1);
                        end else if (out_ready) begin
                            if (out_last_q) begin
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                rd_ptr_q    <= '0;
                                wr_ptr_q    <= '0;
                                state_q     <= S_IDLE;
                            end else begin
                                rd_ptr_q   <= rd_ptr_d;
                                out_data_q <= buf_q[rd_ptr_d[PW-1:0]];
                                out_last_q <= (rd_ptr_d == len_q - 8'd1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
// Directed bench for uart_frame_parser: feeds byte sequences, records every
// out_* handshake and err_pulse, and compares against hand-computed values.
// The timeout test is built only when PARSER_TIMEOUT_EN is defined; otherwise
// a stalled frame is shown to complete without error.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] outQ[$];
    logic       lastQ[$];
    logic [7:0] expQ[$];
    int         errCount;
    int         validCycles;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    uart_frame_parser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .drop_cnt  (drop_cnt)
    );

    // Monitor samples just after the falling edge, where inputs and outputs are settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (out_valid && out_ready) begin
                    outQ.push_back(out_data);
                    lastQ.push_back(out_last);
                end
                if (err_pulse) errCount++;
                if (out_valid) validCycles++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clearMon();
        outQ.delete();
        lastQ.delete();
        expQ.delete();
        errCount    = 0;
        validCycles = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends a well-formed frame with payload base, base+1, ... and queues the expected bytes.
    task automatic sendFrame(input logic [7:0] len, input logic [7:0] base);
        logic [7:0] chk;
        logic [7:0] b;
        chk = len;
        applyStimulus(8'hA5);
        applyStimulus(len);
        for (int i = 0; i < int'(len); i++) begin
            b   = base + 8'(i);
            chk = chk + b;
            expQ.push_back(b);
            applyStimulus(b);
        end
        applyStimulus(chk);
    endtask

    // Compares the recorded handshakes against expQ, including out_last placement.
    task automatic checkStream(input string tag);
        checkOutput({tag, " count"}, outQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s data[%0d]", tag, i),
                        (i < outQ.size()) ? {24'd0, outQ[i]} : 32'hxxxx_xxxx, {24'd0, expQ[i]});
            checkOutput($sformatf("%s last[%0d]", tag, i),
                        (i < lastQ.size()) ? {31'd0, lastQ[i]} : 32'hxxxx_xxxx,
                        (i == expQ.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int fireAt;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        out_ready = 1'b1;
        clearMon();
        idle(3);
        rst = 1'b0;
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset err_pulse", err_pulse, 0);
        checkOutput("reset err_code", err_code, 0);
        checkOutput("reset drop_cnt", drop_cnt, 0);

        // Checksum covers LEN too: 03+11+22+33 = 69.
        $display("[TB] frame A5 03 11 22 33 69");
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
        applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h69);
        expQ = '{8'h11, 8'h22, 8'h33};
        idle(10);
        checkStream("t1");
        checkOutput("t1 errors", errCount, 0);

        // A checksum of 66 omits LEN and must be rejected.
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
        applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h66);
        idle(5);
        checkOutput("t1b errors", errCount, 1);
        checkOutput("t1b code", err_code, 2'b10);
        checkOutput("t1b no valid", validCycles, 0);

        $display("[TB] bad checksum then good frame");
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h10);
        applyStimulus(8'h20); applyStimulus(8'h00);
        idle(5);
        checkOutput("t2 errors", errCount, 1);
        checkOutput("t2 code", err_code, 2'b10);
        checkOutput("t2 no valid", validCycles, 0);
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F); applyStimulus(8'h80);
        expQ = '{8'h7F};
        idle(5);
        checkStream("t2b");
        checkOutput("t2b code held", err_code, 2'b10);
        checkOutput("t2b errors", errCount, 0);

        $display("[TB] LEN boundaries");
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h00);
        idle(3);
        checkOutput("t3 len0 errors", errCount, 1);
        checkOutput("t3 len0 code", err_code, 2'b01);
        applyStimulus(8'hA5); applyStimulus(8'h11);
        idle(3);
        checkOutput("t3 len17 errors", errCount, 2);
        checkOutput("t3 len17 code", err_code, 2'b01);
        clearMon();
        sendFrame(8'd16, 8'h00);
        idle(30);
        checkStream("t3 len16");
        checkOutput("t3 len16 errors", errCount, 0);

        // HEADER inside payload is ordinary data: 02+A5+01 = A8.
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'hA5);
        applyStimulus(8'h01); applyStimulus(8'hA8);
        expQ = '{8'hA5, 8'h01};
        idle(6);
        checkStream("t3 hdr data");

        $display("[TB] backpressure and drops");
        out_ready = 1'b0;
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
        applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h69);
        #1;
        checkOutput("t4 latency 1", out_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("t4 latency 2", out_valid, 1);
        checkOutput("t4 first data", out_data, 8'h11);
        checkOutput("t4 first last", out_last, 0);
        applyStimulus(8'hA5); applyStimulus(8'h55); applyStimulus(8'h00);
        idle(13);
        #1;
        checkOutput("t4 held valid", out_valid, 1);
        checkOutput("t4 held data", out_data, 8'h11);
        checkOutput("t4 drop_cnt", drop_cnt, 3);
        checkOutput("t4 no handshake", outQ.size(), 0);
        @(negedge clk);
        out_ready = 1'b1;
        expQ = '{8'h11, 8'h22, 8'h33};
        idle(8);
        checkStream("t4");
        checkOutput("t4 idle after", out_valid, 0);

        $display("[TB] reset mid-payload");
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t6 out_valid", out_valid, 0);
        checkOutput("t6 out_last", out_last, 0);
        checkOutput("t6 err_pulse", err_pulse, 0);
        checkOutput("t6 err_code", err_code, 0);
        checkOutput("t6 drop_cnt", drop_cnt, 0);
        sendFrame(8'd3, 8'h40);
        idle(10);
        checkStream("t6");
        checkOutput("t6 errors", errCount, 0);

`ifdef PARSER_TIMEOUT_EN
        $display("[TB] inter-byte timeout");
        clearMon();
        fireAt = 0;
        applyStimulus(8'hA5); applyStimulus(8'h04); applyStimulus(8'h01);
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            #1;
            if (err_pulse && fireAt == 0) fireAt = k;
        end
        checkOutput("t5 fire cycle", fireAt, 4500);
        checkOutput("t5 code", err_code, 2'b11);
        checkOutput("t5 errors", errCount, 1);
        clearMon();
        sendFrame(8'd2, 8'h90);
        idle(6);
        checkStream("t5 next");
`else
        $display("[TB] stalled frame without timeout");
        clearMon();
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F);
        idle(5000);
        applyStimulus(8'h80);
        expQ = '{8'h7F};
        idle(5);
        checkStream("t5 stall");
        checkOutput("t5 errors", errCount, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
